rysy_bus_fabric: RTL

//  Parametrised N-slave bus fabric between rysy_core and its memory-mapped slaves (RAM, GPIO, timers, ...).

---
 rtl/rysy_bus_fabric_pkg.sv | 7 +
 rtl/rysy_bus_fabric_decoder.sv | 26 ++
 rtl/rysy_bus_fabric.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rysy_bus_fabric_pkg.sv
// rysy_bus_fabric_pkg: shared FSM states and bus geometry for the rysy bus fabric.
package rysy_bus_fabric_pkg;
    localparam int BUS_WIDTH  = 32;
    localparam int BE_W       = 4;
    localparam int MAX_SLAVES = 8;
    typedef enum logic [1:0] {IDLE, WAIT, ERR, RESP} state_t;
endpackage

// File: rtl/rysy_bus_fabric_decoder.sv
// rysy_bus_fabric_decoder: base/mask window match with lowest-index priority.
module rysy_bus_fabric_decoder
    import rysy_bus_fabric_pkg::*;
#(
    parameter int                        WIDTH      = BUS_WIDTH,
    parameter int                        N_SLAVES   = 2,
    parameter int                        IDX_W      = 1,
    parameter logic [N_SLAVES*WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [N_SLAVES*WIDTH-1:0] SLAVE_MASK = '0
) (
    input  logic [WIDTH-1:0] addr_i,
    output logic             hit_o,
    output logic [IDX_W-1:0] idx_o
);
    // Scanning downwards lets the lowest matching slot overwrite the others.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((addr_i & SLAVE_MASK[i*WIDTH +: WIDTH]) == SLAVE_BASE[i*WIDTH +: WIDTH]) begin
                hit_o = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/rysy_bus_fabric.sv
// rysy_bus_fabric: core-to-N-slave fabric with decode, timeout and error response; RYSY_BUS_STATS_EN adds transfer/error counters.
module rysy_bus_fabric
    import rysy_bus_fabric_pkg::*;
#(
    parameter int                        WIDTH      = BUS_WIDTH,
    parameter int                        N_SLAVES   = 2,
    parameter logic [N_SLAVES*WIDTH-1:0] SLAVE_BASE = {32'h0000_0400, 32'h0000_0000},
    parameter logic [N_SLAVES*WIDTH-1:0] SLAVE_MASK = {32'hFFFF_FC00, 32'hFFFF_FC00},
    parameter int                        TIMEOUT    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [WIDTH-1:0]          addr_i,
    input  logic [WIDTH-1:0]          wdata_i,
    input  logic [BE_W-1:0]           be_i,
    output logic [WIDTH-1:0]          rdata_o,
    output logic                      ready_o,
    output logic                      err_o,
    output logic [WIDTH-1:0]          s_addr_o,
    output logic [WIDTH-1:0]          s_wdata_o,
    output logic [BE_W-1:0]           s_be_o,
    output logic [N_SLAVES-1:0]       s_we_o,
    output logic [N_SLAVES-1:0]       s_re_o,
    input  logic [N_SLAVES*WIDTH-1:0] s_rdata_i,
    input  logic [N_SLAVES-1:0]       s_ready_i
`ifdef RYSY_BUS_STATS_EN
    ,
    output logic [31:0]               stat_xfer_o,
    output logic [31:0]               stat_err_o
`endif
);
    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    state_t              state_q, state_d;
    logic                hit;
    logic [IDX_W-1:0]    hit_idx, idx_q, idx_d;
    logic [N_SLAVES-1:0] onehot;
    logic                we_q, we_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]    rdata_q, rdata_d, s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
    logic [BE_W-1:0]     s_be_q, s_be_d;
    logic [N_SLAVES-1:0] s_we_q, s_we_d, s_re_q, s_re_d;
    logic                ready_q, ready_d, err_q, err_d;
    logic                accept, sel_ready, timeout;
    logic [WIDTH-1:0]    sel_rdata;

    rysy_bus_fabric_decoder #(
        .WIDTH(WIDTH), .N_SLAVES(N_SLAVES), .IDX_W(IDX_W),
        .SLAVE_BASE(SLAVE_BASE), .SLAVE_MASK(SLAVE_MASK)
    ) u_dec (
        .addr_i(addr_i),
        .hit_o (hit),
        .idx_o (hit_idx)
    );

    // The IDLE cycle that carries an error pulse must not re-accept the still-held request.
    assign accept    = state_q == IDLE && req_i && !ready_q;
    assign onehot    = N_SLAVES'(1) << hit_idx;
    assign sel_ready = s_ready_i[idx_q];
    assign sel_rdata = s_rdata_i[idx_q*WIDTH +: WIDTH];
    assign timeout   = cnt_q == 8'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? (hit ? WAIT : ERR) : IDLE;
            WAIT:    state_d = (sel_ready || timeout) ? RESP : WAIT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d     = idx_q;
        we_d      = we_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_be_d    = s_be_q;
        cnt_d     = cnt_q;
        s_we_d    = '0;
        s_re_d    = '0;
        rdata_d   = '0;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        if (accept && hit) begin
            idx_d     = hit_idx;
            we_d      = we_i;
            s_addr_d  = addr_i;
            s_wdata_d = wdata_i;
            s_be_d    = be_i;
            s_we_d    = we_i ? onehot : '0;
            s_re_d    = we_i ? '0 : onehot;
            cnt_d     = '0;
        end
        if (state_q == WAIT) begin
            ready_d = sel_ready || timeout;
            err_d   = !sel_ready && timeout;
            rdata_d = (sel_ready && !we_q) ? sel_rdata : '0;
            cnt_d   = cnt_q + 8'd1;
        end
        if (state_q == ERR) begin
            ready_d = 1'b1;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_be_q    <= '0;
            s_we_q    <= '0;
            s_re_q    <= '0;
        end else begin
            idx_q     <= idx_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_be_q    <= s_be_d;
            s_we_q    <= s_we_d;
            s_re_q    <= s_re_d;
        end
    end

    assign rdata_o   = rdata_q;
    assign ready_o   = ready_q;
    assign err_o     = err_q;
    assign s_addr_o  = s_addr_q;
    assign s_wdata_o = s_wdata_q;
    assign s_be_o    = s_be_q;
    assign s_we_o    = s_we_q;
    assign s_re_o    = s_re_q;

`ifdef RYSY_BUS_STATS_EN
    logic [31:0] stat_xfer_q, stat_err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_xfer_q <= '0;
            stat_err_q  <= '0;
        end else begin
            stat_xfer_q <= stat_xfer_q + {31'd0, ready_q};
            stat_err_q  <= stat_err_q + {31'd0, ready_q & err_q};
        end
    end
    assign stat_xfer_o = stat_xfer_q;
    assign stat_err_o  = stat_err_q;
`endif
endmodule
